// File: rtl/mips_lsu_pkg.sv
// Shared types and lane helpers for the MIPS load/store unit.
// Optional feature macro: MIPS_LSU_ALIGN_CHECK_EN (misaligned requests trap instead of being forced).
package mips_lsu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StResp = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Bit position of the byte lane at offset off; byte 0 is the most significant byte.
  function automatic logic [4:0] byte_shift(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

  // Bit position of the half lane selected by addr[1]; half 0 is the upper half.
  function automatic logic [4:0] half_shift(input logic hi_sel);
    return {~hi_sel, 4'b0000};
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    if (size[1]) return off != 2'b00;
    if (size == SZ_HALF) return off[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/mips_load_store_unit_if.sv
// Core-side request/response bundle of the MIPS load/store unit.
// Optional feature macro: MIPS_LSU_ALIGN_CHECK_EN adds misalign_exc.
interface mips_load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
  logic        misalign_exc;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, misalign_exc
  );
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, misalign_exc
  );
`else
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
`endif
endinterface

// File: rtl/mips_lsu_lane.sv
// Combinational lane logic: big-endian extract/extend for loads, lane merge for sb/sh.
// Misaligned halves/words are forced onto their natural lane (half uses off[1], word ignores off).
module mips_lsu_lane
  import mips_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  shift;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_wdata;

  // Select the lane, extend it for loads and build the insert mask for stores.
  always_comb begin
    shift      = '0;
    shifted    = rdata_i;
    lane_mask  = '0;
    lane_wdata = '0;
    load_o     = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        shift      = byte_shift(off_i);
        shifted    = rdata_i >> shift;
        load_o     = unsigned_i ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        lane_mask  = 32'h0000_00ff << shift;
        lane_wdata = {24'b0, wdata_i[7:0]} << shift;
      end
      SZ_HALF: begin
        shift      = half_shift(off_i[1]);
        shifted    = rdata_i >> shift;
        load_o     = unsigned_i ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        lane_mask  = 32'h0000_ffff << shift;
        lane_wdata = {16'b0, wdata_i} << shift;
      end
      SZ_WORD: load_o = rdata_i;
      default: load_o = rdata_i;
    endcase
    merge_o = (rdata_i & ~lane_mask) | (lane_wdata & lane_mask);
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// MIPS load/store unit: turns one core load/store into word-wide accesses to mips_data_mem,
// using read-modify-write for sb/sh.
// Optional feature macro: MIPS_LSU_ALIGN_CHECK_EN (misaligned requests answer at once with
// misalign_exc and never touch memory).
module mips_load_store_unit
  import mips_lsu_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mips_load_store_unit_if.slave        bus,
  output logic [31:0]                  mem_address,
  output logic [31:0]                  write_data,
  output logic                         sig_mem_read,
  output logic                         sig_mem_write,
  input  logic [31:0]                  read_data
);

  localparam logic [3:0] LastCnt = 4'(MEM_WAIT - 1);

  lsu_state_e  state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  logic [31:0] load_data;
  logic [31:0] merge_data;

  mips_lsu_lane u_lane (
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .off_i      (off_q),
    .rdata_i    (read_data),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  // Access FSM with wait counter; every output is a registered decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      write_q           <= 1'b0;
      size_q            <= SZ_BYTE;
      unsigned_q        <= 1'b0;
      off_q             <= 2'b00;
      wdata_q           <= '0;
      bus.req_ready     <= 1'b1;
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= '0;
      mem_address       <= '0;
      write_data        <= '0;
      sig_mem_read      <= 1'b0;
      sig_mem_write     <= 1'b0;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
      bus.misalign_exc  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // req_ready is high throughout IDLE, so req_valid alone marks a transfer.
          if (bus.req_valid) begin
            write_q       <= bus.req_write;
            size_q        <= bus.req_size;
            unsigned_q    <= bus.req_unsigned;
            off_q         <= bus.req_addr[1:0];
            wdata_q       <= bus.req_wdata[15:0];
            mem_address   <= {bus.req_addr[31:2], 2'b00};
            cnt_q         <= '0;
            bus.req_ready <= 1'b0;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
            if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
              state_q          <= StResp;
              bus.resp_valid   <= 1'b1;
              bus.resp_rdata   <= '0;
              bus.misalign_exc <= 1'b1;
            end else
`endif
            if (bus.req_write && bus.req_size[1]) begin
              // Full-word store needs no read.
              state_q       <= StWr;
              sig_mem_write <= 1'b1;
              write_data    <= bus.req_wdata;
            end else begin
              state_q      <= StRd;
              sig_mem_read <= 1'b1;
            end
          end
        end
        StRd: begin
          if (cnt_q == LastCnt) begin
            cnt_q        <= '0;
            sig_mem_read <= 1'b0;
            if (write_q) begin
              state_q       <= StWr;
              sig_mem_write <= 1'b1;
              write_data    <= merge_data;
            end else begin
              state_q        <= StResp;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= load_data;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StWr: begin
          if (cnt_q == LastCnt) begin
            cnt_q          <= '0;
            sig_mem_write  <= 1'b0;
            state_q        <= StResp;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StResp: begin
          state_q          <= StIdle;
          bus.resp_valid   <= 1'b0;
          bus.req_ready    <= 1'b1;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
          bus.misalign_exc <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Self-checking bench for mips_load_store_unit: two instances (MEM_WAIT 1 and 3) on word memories,
// checked against a behavioural big-endian byte-lane model.
module tb_mips_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_load_store_unit_if bus1 ();
  mips_load_store_unit_if bus3 ();

  logic [31:0] mem_address1, write_data1, read_data1;
  logic [31:0] mem_address3, write_data3, read_data3;
  logic        rd1, wr1, rd3, wr3;

  logic [31:0] mem1 [16];
  logic [31:0] mem3 [16];
  logic [31:0] ref1 [16];
  logic [31:0] ref3 [16];
  logic        pre_load;

  int checks = 0;
  int fails  = 0;

  mips_load_store_unit #(.MEM_WAIT(1)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus1),
    .mem_address   (mem_address1),
    .write_data    (write_data1),
    .sig_mem_read  (rd1),
    .sig_mem_write (wr1),
    .read_data     (read_data1)
  );

  mips_load_store_unit #(.MEM_WAIT(3)) u_dut3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus3),
    .mem_address   (mem_address3),
    .write_data    (write_data3),
    .sig_mem_read  (rd3),
    .sig_mem_write (wr3),
    .read_data     (read_data3)
  );

  assign read_data1 = mem1[mem_address1[5:2]];
  assign read_data3 = mem3[mem_address3[5:2]];

  // Data memories: DUT writes, or bulk copy of the reference image.
  always @(posedge clk) begin
    if (wr1) mem1[mem_address1[5:2]] <= write_data1;
    else if (pre_load) for (int i = 0; i < 16; i++) mem1[i] <= ref1[i];
    if (wr3) mem3[mem_address3[5:2]] <= write_data3;
    else if (pre_load) for (int i = 0; i < 16; i++) mem3[i] <= ref3[i];
  end

  typedef struct {
    logic        ready, rv, rd, wr, exc;
    logic [31:0] rdata, wdata, addr;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_load(logic [31:0] word, logic [1:0] sz, logic u,
                                           logic [31:0] a);
    logic [31:0] v;
    int          off;
    if (sz == 2'b00) begin
      off = int'(a[1:0]);
      v = (word >> (8 * (3 - off))) & 32'hff;
      if (!u && v >= 32'd128) v = v + 32'hffff_ff00;
    end else if (sz == 2'b01) begin
      off = a[1] ? 2 : 0;
      v = (word >> (8 * (2 - off))) & 32'hffff;
      if (!u && v >= 32'd32768) v = v + 32'hffff_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_merge(logic [31:0] word, logic [1:0] sz, logic [31:0] a,
                                            logic [31:0] wd);
    int pos;
    if (sz == 2'b00) begin
      pos = 8 * (3 - int'(a[1:0]));
      return (word & ~(32'hff << pos)) | ((wd & 32'hff) << pos);
    end else if (sz == 2'b01) begin
      pos = a[1] ? 0 : 16;
      return (word & ~(32'hffff << pos)) | ((wd & 32'hffff) << pos);
    end
    return wd;
  endfunction

  function automatic logic model_mis(logic [1:0] sz, logic [31:0] a);
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    if (sz == 2'b01) return a[0];
    if (sz[1]) return a[1:0] != 2'b00;
    return 1'b0;
`else
    return (sz == 2'b11) && (a == 32'hffff_ffff) && 1'b0;
`endif
  endfunction

  // ---------------- drivers / samplers ----------------
  task automatic drive(input int d, input logic v, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] wd);
    if (d == 1) begin
      bus1.req_valid = v; bus1.req_write = w; bus1.req_size = sz;
      bus1.req_unsigned = u; bus1.req_addr = a; bus1.req_wdata = wd;
    end else begin
      bus3.req_valid = v; bus3.req_write = w; bus3.req_size = sz;
      bus3.req_unsigned = u; bus3.req_addr = a; bus3.req_wdata = wd;
    end
  endtask

  task automatic sample(input int d, output obs_t o);
    if (d == 1) begin
      o.ready = bus1.req_ready; o.rv = bus1.resp_valid; o.rdata = bus1.resp_rdata;
      o.rd = rd1; o.wr = wr1; o.wdata = write_data1; o.addr = mem_address1;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
      o.exc = bus1.misalign_exc;
`else
      o.exc = 1'b0;
`endif
    end else begin
      o.ready = bus3.req_ready; o.rv = bus3.resp_valid; o.rdata = bus3.resp_rdata;
      o.rd = rd3; o.wr = wr3; o.wdata = write_data3; o.addr = mem_address3;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
      o.exc = bus3.misalign_exc;
`else
      o.exc = 1'b0;
`endif
    end
  endtask

  task automatic load_mem();
    @(negedge clk); pre_load = 1'b1;
    @(posedge clk); #1; pre_load = 1'b0;
  endtask

  // One request: n_resp counts edges after the accept edge until resp_valid is seen (-1 on timeout).
  task automatic run_op(input int d, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int n_resp, output int n_rd, output int n_wr,
                        output logic [31:0] rdata, output logic [31:0] wseen,
                        output logic [31:0] aseen, output logic exc, output int both);
    obs_t o;
    n_resp = -1; n_rd = 0; n_wr = 0; both = 0;
    rdata = '0; wseen = '0; aseen = '0; exc = 1'b0;
    @(negedge clk); drive(d, 1'b1, w, sz, u, a, wd);
    @(posedge clk); #1; drive(d, 1'b0, w, sz, u, a, wd);
    for (int n = 0; n < 100; n++) begin
      sample(d, o);
      if (o.rd) n_rd++;
      if (o.wr) begin n_wr++; wseen = o.wdata; end
      if (o.rd && o.wr) both++;
      if (o.rv) begin
        n_resp = n; rdata = o.rdata; exc = o.exc; aseen = o.addr;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    pre_load = 1'b0;
    drive(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin ref1[i] = $urandom(); ref3[i] = $urandom(); end
    load_mem();
    for (int d = 1; d <= 3; d += 2) begin
      sample(d, o);
      checks++;
      if (o.ready !== 1'b1 || o.rv !== 1'b0 || o.rdata !== 32'h0 || o.addr !== 32'h0 ||
          o.wdata !== 32'h0 || o.rd !== 1'b0 || o.wr !== 1'b0 || o.exc !== 1'b0) begin
        fails++;
        $display("FAIL reset_state dut%0d: ready=%b rv=%b rdata=%h addr=%h wdata=%h rd=%b wr=%b exc=%b required 1 0 0 0 0 0 0 0",
                 d, o.ready, o.rv, o.rdata, o.addr, o.wdata, o.rd, o.wr, o.exc);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    // Abort a load mid-RD on the slow instance.
    @(negedge clk); drive(3, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0);
    @(posedge clk); #1; drive(3, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    sample(3, o);
    checks++;
    if (o.rd !== 1'b1) begin
      fails++; $display("FAIL reset_pre_rd: sig_mem_read=%b required 1", o.rd);
    end
    #2 rst_n = 1'b0;
    #1 sample(3, o);
    checks++;
    if (o.rd !== 1'b0 || o.wr !== 1'b0 || o.ready !== 1'b1 || o.addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_rd: rd=%b wr=%b ready=%b addr=%h required 0 0 1 0",
               o.rd, o.wr, o.ready, o.addr);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; sample(3, o);
    checks++;
    if (o.ready !== 1'b1 || o.rv !== 1'b0 || o.rd !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready=%b rv=%b rd=%b required 1 0 0", o.ready, o.rv, o.rd);
    end
  endtask

  typedef struct {
    int d; logic w; logic [1:0] sz; logic u; logic [31:0] a; logic [31:0] wd;
    logic [31:0] er; int en; int erd; int ewr; logic [31:0] ew;
  } dir_t;

  task automatic test_directed();
    dir_t t [9];
    int n, nr, nw, bo;
    logic [31:0] rdata, ws, as;
    logic exc;
    t[0] = '{1, 0, 2'b10, 0, 32'h10, 32'h0,    32'h8899aabb, 1, 1, 0, 32'h0};
    t[1] = '{1, 0, 2'b00, 0, 32'h11, 32'h0,    32'hffffff99, 1, 1, 0, 32'h0};
    t[2] = '{1, 0, 2'b00, 1, 32'h11, 32'h0,    32'h00000099, 1, 1, 0, 32'h0};
    t[3] = '{1, 0, 2'b01, 0, 32'h12, 32'h0,    32'hffffaabb, 1, 1, 0, 32'h0};
    t[4] = '{1, 0, 2'b01, 1, 32'h12, 32'h0,    32'h0000aabb, 1, 1, 0, 32'h0};
    t[5] = '{1, 1, 2'b00, 0, 32'h13, 32'hcc,   32'h0,        2, 1, 1, 32'h8899aacc};
    t[6] = '{1, 0, 2'b10, 0, 32'h10, 32'h0,    32'h8899aacc, 1, 1, 0, 32'h0};
    t[7] = '{3, 1, 2'b01, 0, 32'h10, 32'h1234, 32'h0,        6, 3, 3, 32'h1234aabb};
    t[8] = '{3, 0, 2'b10, 0, 32'h10, 32'h0,    32'h1234aabb, 3, 3, 0, 32'h0};
    ref1[4] = 32'h8899aabb; ref3[4] = 32'h8899aabb;
    load_mem();
    for (int i = 0; i < 9; i++) begin
      run_op(t[i].d, t[i].w, t[i].sz, t[i].u, t[i].a, t[i].wd, n, nr, nw, rdata, ws, as, exc, bo);
      checks++;
      if (rdata !== t[i].er || n != t[i].en || nr != t[i].erd || nw != t[i].ewr ||
          as !== 32'h10 || bo != 0) begin
        fails++;
        $display("FAIL directed_%0d: rdata=%h lat=%0d rd=%0d wr=%0d addr=%h both=%0d required %h %0d %0d %0d 00000010 0",
                 i, rdata, n, nr, nw, as, bo, t[i].er, t[i].en, t[i].erd, t[i].ewr);
      end
      if (t[i].w) begin
        checks++;
        if (ws !== t[i].ew) begin
          fails++; $display("FAIL directed_%0d_wdata: write_data=%h required %h", i, ws, t[i].ew);
        end
      end
    end
    ref1[4] = 32'h8899aacc; ref3[4] = 32'h1234aabb;
  endtask

  task automatic test_random();
    int d, mw, n, nr, nw, bo, en, erd, ewr;
    logic w, u, mis, exc, eexc;
    logic [1:0] sz;
    logic [31:0] a, wd, word, er, ew, rdata, ws, as, hi;
    logic [3:0] idx;
    for (int i = 0; i < 80; i++) begin
      d = ($urandom_range(0, 1) == 0) ? 1 : 3;
      mw = (d == 1) ? 1 : 3;
      w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      hi = $urandom();
      a = {hi[31:6], 6'($urandom_range(0, 63))};
      wd = $urandom();
      idx = a[5:2];
      word = (d == 1) ? ref1[idx] : ref3[idx];
      mis = model_mis(sz, a);
      er = 32'h0; ew = 32'h0; eexc = 1'b0;
      if (mis) begin
        en = 0; erd = 0; ewr = 0; eexc = 1'b1;
      end else if (!w) begin
        en = mw; erd = mw; ewr = 0; er = exp_load(word, sz, u, a);
      end else if (sz[1]) begin
        en = mw; erd = 0; ewr = mw; ew = wd;
      end else begin
        en = 2 * mw; erd = mw; ewr = mw; ew = exp_merge(word, sz, a, wd);
      end
      if (w && !mis) begin
        if (d == 1) ref1[idx] = ew; else ref3[idx] = ew;
      end
      run_op(d, w, sz, u, a, wd, n, nr, nw, rdata, ws, as, exc, bo);
      checks++;
      if (rdata !== er || n != en || nr != erd || nw != ewr || exc !== eexc ||
          as !== {a[31:2], 2'b00} || bo != 0 || (ewr > 0 && ws !== ew)) begin
        fails++;
        $display("FAIL random_%0d dut%0d w=%b sz=%0d u=%b a=%h: rdata=%h lat=%0d rd=%0d wr=%0d exc=%b addr=%h both=%0d wdata=%h required %h %0d %0d %0d %b %h 0 %h",
                 i, d, w, sz, u, a, rdata, n, nr, nw, exc, as, bo, ws,
                 er, en, erd, ewr, eexc, {a[31:2], 2'b00}, ew);
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem1[i] !== ref1[i] || mem3[i] !== ref3[i]) begin
        fails++;
        $display("FAIL mem_image_%0d: mem1=%h mem3=%h required %h %h",
                 i, mem1[i], mem3[i], ref1[i], ref3[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    ref1[2] = 32'hdead_beef; ref1[3] = 32'h0bad_cafe;
    load_mem();
    @(negedge clk); drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    @(posedge clk); #1; sample(1, o);
    checks++;
    if (o.rd !== 1'b1 || o.ready !== 1'b0) begin
      fails++; $display("FAIL b2b_first_rd: rd=%b ready=%b required 1 0", o.rd, o.ready);
    end
    @(posedge clk); #1; sample(1, o);
    checks++;
    if (o.rv !== 1'b1 || o.rdata !== 32'hdead_beef || o.ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first_resp: rv=%b rdata=%h ready=%b required 1 deadbeef 0",
               o.rv, o.rdata, o.ready);
    end
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0c, 32'h0);
    @(posedge clk); #1; sample(1, o);
    checks++;
    if (o.ready !== 1'b1 || o.rd !== 1'b0 || o.rv !== 1'b0) begin
      fails++;
      $display("FAIL b2b_gap: ready=%b rd=%b rv=%b required 1 0 0", o.ready, o.rd, o.rv);
    end
    @(posedge clk); #1; sample(1, o);
    drive(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    checks++;
    if (o.rd !== 1'b1 || o.addr !== 32'h0c) begin
      fails++; $display("FAIL b2b_second_rd: rd=%b addr=%h required 1 0000000c", o.rd, o.addr);
    end
    @(posedge clk); #1; sample(1, o);
    checks++;
    if (o.rv !== 1'b1 || o.rdata !== 32'h0bad_cafe) begin
      fails++; $display("FAIL b2b_second_resp: rv=%b rdata=%h required 1 0badcafe", o.rv, o.rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
    logic [1:0]  sz [3];
    logic [31:0] ad [3];
    logic        wr [3];
    int n, nr, nw, bo, en, erd, ewr;
    logic [31:0] rdata, ws, as, er;
    logic exc, eexc;
    sz[0] = 2'b10; ad[0] = 32'h12; wr[0] = 1'b0;
    sz[1] = 2'b01; ad[1] = 32'h11; wr[1] = 1'b0;
    sz[2] = 2'b10; ad[2] = 32'h13; wr[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
`ifdef MIPS_LSU_ALIGN_CHECK_EN
      en = 0; erd = 0; ewr = 0; er = 32'h0; eexc = 1'b1;
`else
      en = 1; erd = wr[i] ? 0 : 1; ewr = wr[i] ? 1 : 0; eexc = 1'b0;
      er = wr[i] ? 32'h0 : exp_load(ref1[4], sz[i], 1'b0, ad[i]);
      if (wr[i]) ref1[4] = 32'h5a5a_1234;
`endif
      run_op(1, wr[i], sz[i], 1'b0, ad[i], 32'h5a5a_1234, n, nr, nw, rdata, ws, as, exc, bo);
      checks++;
      if (n != en || nr != erd || nw != ewr || rdata !== er || exc !== eexc) begin
        fails++;
        $display("FAIL misalign_%0d: lat=%0d rd=%0d wr=%0d rdata=%h exc=%b required %0d %0d %0d %h %b",
                 i, n, nr, nw, rdata, exc, en, erd, ewr, er, eexc);
      end
    end
    checks++;
    if (mem1[4] !== ref1[4]) begin
      fails++; $display("FAIL misalign_mem: mem=%h required %h", mem1[4], ref1[4]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
